// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
//   word_t / instr_t  : 64-bit address word and 32-bit instruction word
//   DEFAULT_RESET_PC  : default first fetch address after reset
//   fetch_state_t     : REQ (request on the bus) / HOLD (response parked in buffer)
//   fetch_data_t      : {valid, pc, instr} record handed from fetch to decode
package fetch_pkg;

    // Common types and constants
    typedef logic [63:0] word_t;
    typedef logic [31:0] instr_t;

    localparam word_t DEFAULT_RESET_PC = 64'h8000_0000;
    localparam word_t PC_STEP          = 64'd4;

    // Pipeline types
    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic   valid;
        word_t  pc;
        instr_t instr;
    } fetch_data_t;

    // Sequential PC advance; the add wraps modulo 2^64 by construction.
    function automatic word_t next_pc(input word_t pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_ibuf.sv
// One-entry holding register for a fetched {pc, instr} pair that arrived while
// downstream was stalled.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   load                capture load_pc/load_instr and mark full
//   clear               empty the buffer (wins over load)
//   load_pc, load_instr pair to capture
//   full                buffer holds a pair
//   pc, instr           held pair
module fetch_ibuf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [63:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        full,
    output logic [63:0] pc,
    output logic [31:0] instr
);

    logic   full_reg;
    word_t  pc_reg;
    instr_t instr_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            full_reg  <= 1'b0;
            pc_reg    <= '0;
            instr_reg <= '0;
        end else if (clear) begin
            // Contents are left in place; only the full flag matters to the reader.
            full_reg  <= 1'b0;
        end else if (load) begin
            full_reg  <= 1'b1;
            pc_reg    <= load_pc;
            instr_reg <= load_instr;
        end
    end

    assign full  = full_reg;
    assign pc    = pc_reg;
    assign instr = instr_reg;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage. Owns the PC, keeps at most one instruction-bus
// request outstanding and registers {valid, pc, instr} into dataF for decode.
// Responses arriving during a downstream stall are parked in fetch_ibuf.
// Ports:
//   clk, reset              clock, synchronous active-low reset
//   stopd, stope, stopm     decode / execute / memory stalls
//   branch, branch_pc       one-cycle redirect from execute and its target
//   ireq_valid, ireq_addr   instruction-bus request (address = pc)
//   iresp_data_ok, iresp_data  one-cycle response handshake and instruction word
//   dataF                   registered fetch record for decode
module fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stopd,
    input  logic        stope,
    input  logic        stopm,
    input  logic        branch,
    input  logic [63:0] branch_pc,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output fetch_data_t dataF
);

    fetch_state_t state_reg, state_next;
    word_t        pc_reg, pc_next;
    logic         drop_reg, drop_next;
    fetch_data_t  data_reg, data_next;

    logic   stall;
    logic   buf_load, buf_clear;
    logic   buf_full;
    word_t  buf_pc;
    instr_t buf_instr;

    assign stall = stopd | stope | stopm;

    fetch_ibuf u_ibuf (
        .clk        (clk),
        .reset      (reset),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_pc    (pc_reg),
        .load_instr (iresp_data),
        .full       (buf_full),
        .pc         (buf_pc),
        .instr      (buf_instr)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= REQ;
            pc_reg    <= RESET_PC;
            drop_reg  <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            drop_reg  <= drop_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        drop_next  = drop_reg;
        data_next  = data_reg;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;

        if (branch) begin
            // Redirect wins over everything, stalled or not.
            pc_next         = branch_pc;
            buf_clear       = 1'b1;
            data_next.valid = 1'b0;
            state_next      = REQ;
            // A request still in flight (REQ without a handshake this cycle)
            // will answer later with a stale word; mark it for discard. If the
            // handshake lands now, that response is simply ignored and nothing
            // remains outstanding.
            drop_next       = (state_reg == REQ) && !iresp_data_ok;
        end else if (state_reg == REQ && iresp_data_ok && drop_reg) begin
            // Stale response from before a redirect: swallow it and re-issue at pc.
            drop_next = 1'b0;
        end else if (state_reg == REQ && iresp_data_ok && !stall) begin
            data_next.valid = 1'b1;
            data_next.pc    = pc_reg;
            data_next.instr = iresp_data;
            pc_next         = next_pc(pc_reg);
        end else if (state_reg == REQ && iresp_data_ok) begin
            // Downstream is stalled: park the word and stop requesting.
            buf_load   = 1'b1;
            pc_next    = next_pc(pc_reg);
            state_next = HOLD;
        end else if (state_reg == HOLD && !stall) begin
            data_next.valid = buf_full;
            data_next.pc    = buf_pc;
            data_next.instr = buf_instr;
            buf_clear       = 1'b1;
            state_next      = REQ;
        end else if (!stall) begin
            data_next.valid = 1'b0;
        end
    end

    // The request drops during reset so no handshake is started on a PC that
    // is about to be reloaded.
    assign ireq_valid = reset && (state_reg == REQ);
    assign ireq_addr  = pc_reg;
    assign dataF      = data_reg;

endmodule
